freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/edge_sync.sv | 33 +++
 rtl/freq_meter.sv | 117 +++++++++++
 tb/tb_freq_meter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Brief    : Shared state encoding and default constants for timing blocks.
// Revision : 1.0
// ============================================================================
package freq_meter_pkg;

    localparam int c_gate_cycles_def = 50_000_000;
    localparam int c_cnt_w_def       = 27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Brief    : Two-flop synchronizer plus history flop; one-cycle rise pulse.
// Revision : 1.0
// ============================================================================
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign rise = r_sync & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Brief    : Gated rising-edge counter; reports edges per GATE_CYCLES window.
// Revision : 1.0
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = c_gate_cycles_def,
    parameter int CNT_W       = c_cnt_w_def
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    localparam int                    c_gate_w    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_gate_w-1:0]   c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_cnt_max   = '1;

    meter_state_t          r_state;
    meter_state_t          w_state_nxt;
    logic [c_gate_w-1:0]   r_gate_cnt;
    logic [CNT_W-1:0]      r_edge_cnt;
    logic                  r_sat;
    logic [CNT_W-1:0]      r_freq;
    logic                  r_ovf;
    logic                  w_rise;
    logic                  w_gate_end;
    logic                  w_at_max;
    logic [CNT_W-1:0]      w_edge_inc;
    logic                  w_sat_nxt;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .rise     (w_rise)
    );

    assign w_gate_end = (r_gate_cnt == c_gate_last);
    assign w_at_max   = (r_edge_cnt == c_cnt_max);
    assign w_edge_inc = (w_rise && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_sat_nxt  = r_sat | (w_rise & w_at_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_GATE;
            ST_GATE: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_gate_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = en ? ST_GATE : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result registers load on the GATE->DONE edge so they are already
    // current during the single DONE cycle in which valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_freq     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_GATE: begin
                    r_gate_cnt <= w_gate_end ? '0 : r_gate_cnt + c_gate_w'(1);
                    r_edge_cnt <= w_edge_inc;
                    r_sat      <= w_sat_nxt;
                    if (en && w_gate_end) begin
                        r_freq <= w_edge_inc;
                        r_ovf  <= w_sat_nxt;
                    end
                end
                ST_DONE: begin
                    // An edge seen here belongs to the window that follows.
                    r_gate_cnt <= '0;
                    r_edge_cnt <= CNT_W'(w_rise);
                    r_sat      <= 1'b0;
                end
                default: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                end
            endcase
        end
    end

    assign freq  = r_freq;
    assign ovf   = r_ovf;
    assign valid = (r_state == ST_DONE);
    assign busy  = (r_state == ST_GATE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Brief    : Scoreboard bench for freq_meter (CNT_W=8 and CNT_W=5 instances).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int GC  = 100;
    localparam int WIN = GC + 1;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] freq;
    logic       valid, ovf, busy;
    logic [4:0] freq5;
    logic       valid5, ovf5, busy5;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq(freq), .valid(valid), .ovf(ovf), .busy(busy)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .freq(freq5), .valid(valid5), .ovf(ovf5), .busy(busy5)
    );

    always #5 clk = ~clk;

    // sig_in as seen at each rising edge, indexed by edge number
    logic smp [0:8191];
    int   cyc = 0;
    always @(posedge clk) begin
        if (cyc < 8192) smp[cyc] <= sig_in;
        cyc <= cyc + 1;
    end

    typedef struct {
        int         idx;
        logic [7:0] f8;
        logic       o8;
        logic [4:0] f5;
        logic       o5;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    int   win_e  = 0;
    bit   win_on = 1'b0;
    int   win_k  = 0;

    int   mode = 0;
    logic lvl  = 1'b0;
    int   per  = 10;
    int   ph   = 0;

    // A synchronized rise is counted at edge t when sig_in was 1 at edge t-2
    // and 0 at edge t-3.
    function automatic int count_rises(int a, int b);
        int n = 0;
        for (int t = a; t <= b; t++)
            if (t >= 3 && smp[t-2] === 1'b1 && smp[t-3] === 1'b0) n++;
        return n;
    endfunction

    task automatic tick();
        int   s, ent, cnt;
        exp_t e;
        @(negedge clk);
        if (win_on && cyc == win_e + WIN*win_k + GC - 1) begin
            ent = win_e + WIN*win_k + GC;
            s   = (win_k == 0) ? win_e + 1 : win_e + WIN*win_k;
            cnt = count_rises(s, ent);
            e.idx = win_k;
            e.f8  = (cnt > 255) ? 8'd255 : 8'(cnt);
            e.o8  = (cnt > 255);
            e.f5  = (cnt > 31) ? 5'd31 : 5'(cnt);
            e.o5  = (cnt > 31);
            sb_q.push_back(e);
            win_k++;
        end
        if (mode == 0) begin
            sig_in = lvl;
        end else begin
            if (ph == 0 && mode == 2) per = int'($urandom_range(20, 3));
            sig_in = (ph < per/2);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
    endtask

    task automatic start_window();
        en     = 1'b1;
        win_e  = cyc;
        win_on = 1'b1;
        win_k  = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 0; lvl = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({freq, valid, ovf, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_dut8: freq=%0d valid=%b ovf=%b busy=%b, want all 0", freq, valid, ovf, busy);
        end
        n_assert++;
        if ({freq5, valid5, ovf5, busy5} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_dut5: freq=%0d valid=%b ovf=%b busy=%b, want all 0", freq5, valid5, ovf5, busy5);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        n_assert++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_en: busy=%b valid=%b, want 0 0", busy, valid);
        end
    endtask

    task automatic test_period10();
        exp_t e;
        int   got = 0, last = -1, lim;
        mode = 1; per = 10; ph = 0;
        tick();
        start_window();
        tick();
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL p10_busy: busy=%b, want 1", busy);
        end
        lim = cyc + 3*WIN + 10;
        while (got < 3 && cyc < lim) begin
            tick();
            if (valid) begin
                n_assert++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL p10_sb_empty: valid with no expected window");
                end else begin
                    e = sb_q.pop_front();
                    if (freq !== e.f8 || ovf !== e.o8 || freq5 !== e.f5 || ovf5 !== e.o5 || valid5 !== 1'b1) begin
                        n_fail++;
                        $display("FAIL p10_win%0d: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                                 e.idx, freq, ovf, freq5, ovf5, e.f8, e.o8, e.f5, e.o5);
                    end
                end
                if (got == 0) begin
                    n_assert++;
                    if (freq !== 8'd10 || ovf !== 1'b0 || cyc - win_e != WIN) begin
                        n_fail++;
                        $display("FAIL p10_first: freq=%0d ovf=%b after %0d cycles, want 10 0 after %0d",
                                 freq, ovf, cyc - win_e, WIN);
                    end
                end
                if (last >= 0) begin
                    n_assert++;
                    if (cyc - last != WIN) begin
                        n_fail++;
                        $display("FAIL p10_period: valid spacing %0d, want %0d", cyc - last, WIN);
                    end
                end
                last = cyc;
                got++;
            end
        end
        n_assert++;
        if (got < 3) begin
            n_fail++;
            $display("FAIL p10_timeout: %0d valid pulses, want 3", got);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int   got = 0, lim, k0;
        k0 = win_k;
        mode = 1; per = 2; ph = 0;
        lim = cyc + 2*WIN + 20;
        while (got < 2 && cyc < lim) begin
            tick();
            if (mode == 1 && win_k == k0 && cyc == win_e + WIN*k0 + 90) begin
                mode = 0; lvl = 1'b0;
            end
            if (valid) begin
                n_assert++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sat_sb_empty: valid with no expected window");
                end else begin
                    e = sb_q.pop_front();
                    if (freq !== e.f8 || ovf !== e.o8 || freq5 !== e.f5 || ovf5 !== e.o5) begin
                        n_fail++;
                        $display("FAIL sat_win%0d: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                                 e.idx, freq, ovf, freq5, ovf5, e.f8, e.o8, e.f5, e.o5);
                    end
                    n_assert++;
                    if (e.idx == k0 && (freq5 !== 5'd31 || ovf5 !== 1'b1 || ovf !== 1'b0)) begin
                        n_fail++;
                        $display("FAIL sat_full: freq5=%0d ovf5=%b ovf=%b, want 31 1 0", freq5, ovf5, ovf);
                    end else if (e.idx != k0 && {freq, ovf, freq5, ovf5} !== 15'd0) begin
                        n_fail++;
                        $display("FAIL sat_static: freq=%0d ovf=%b freq5=%0d ovf5=%b, want all 0", freq, ovf, freq5, ovf5);
                    end
                end
                got++;
            end
        end
        n_assert++;
        if (got < 2) begin
            n_fail++;
            $display("FAIL sat_timeout: %0d valid pulses, want 2", got);
        end
    endtask

    task automatic test_abort();
        exp_t       e;
        int         got = 0, nv = 0, lim, target;
        logic [7:0] f_prev;
        logic       o_prev;
        mode = 1; per = 10; ph = 0;
        target = win_e + WIN*win_k + 51;
        lim = cyc + 2*WIN;
        while (cyc != target && cyc < lim) tick();
        en = 1'b0; win_on = 1'b0;
        f_prev = freq; o_prev = ovf;
        tick();
        n_assert++;
        if (busy !== 1'b0 || busy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: busy=%b busy5=%b, want 0 0", busy, busy5);
        end
        for (int i = 0; i < 150; i++) begin
            tick();
            if (valid || valid5) nv++;
        end
        n_assert++;
        if (nv != 0) begin
            n_fail++;
            $display("FAIL abort_valid: %0d valid cycles after abort, want 0", nv);
        end
        n_assert++;
        if (freq !== f_prev || ovf !== o_prev) begin
            n_fail++;
            $display("FAIL abort_hold: freq=%0d ovf=%b, want %0d %b", freq, ovf, f_prev, o_prev);
        end
        per = 7; ph = 0;
        start_window();
        lim = cyc + 2*WIN + 10;
        while (got < 2 && cyc < lim) begin
            tick();
            if (valid) begin
                n_assert++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL restart_sb_empty: valid with no expected window");
                end else begin
                    e = sb_q.pop_front();
                    if (freq !== e.f8 || ovf !== e.o8 || freq5 !== e.f5 || ovf5 !== e.o5) begin
                        n_fail++;
                        $display("FAIL restart_win%0d: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                                 e.idx, freq, ovf, freq5, ovf5, e.f8, e.o8, e.f5, e.o5);
                    end
                end
                got++;
            end
        end
        n_assert++;
        if (got < 2) begin
            n_fail++;
            $display("FAIL restart_timeout: %0d valid pulses, want 2", got);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lim, target;
        bit   seen = 1'b0;
        target = win_e + WIN*win_k + 41;
        lim = cyc + 2*WIN;
        while (cyc != target && cyc < lim) tick();
        #2;
        rst_n = 1'b0; sig_in = 1'b0; mode = 0; lvl = 1'b0; win_on = 1'b0;
        #1;
        n_assert++;
        if ({freq, valid, ovf, busy, freq5, valid5, ovf5, busy5} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: freq=%0d valid=%b ovf=%b busy=%b freq5=%0d, want all 0",
                     freq, valid, ovf, busy, freq5);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        win_e = cyc; win_on = 1'b1; win_k = 0;
        mode = 1; per = 6; ph = 0;
        lim = cyc + WIN + 10;
        while (!seen && cyc < lim) begin
            tick();
            if (valid) begin
                seen = 1'b1;
                n_assert++;
                if (cyc - win_e != WIN) begin
                    n_fail++;
                    $display("FAIL rst_mid_latency: first valid after %0d cycles, want %0d", cyc - win_e, WIN);
                end
                n_assert++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_mid_sb_empty: valid with no expected window");
                end else begin
                    e = sb_q.pop_front();
                    if (freq !== e.f8 || ovf !== e.o8 || freq5 !== e.f5 || ovf5 !== e.o5) begin
                        n_fail++;
                        $display("FAIL rst_mid_win%0d: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                                 e.idx, freq, ovf, freq5, ovf5, e.f8, e.o8, e.f5, e.o5);
                    end
                end
            end
        end
        n_assert++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid_timeout: no valid after reset release");
        end
    endtask

    task automatic test_done_edge();
        exp_t e;
        int   got = 0, lim, kk, d_edge;
        mode = 0; lvl = 1'b0;
        kk = win_k + 1;
        d_edge = win_e + WIN*(kk + 1);
        lim = cyc + 3*WIN + 10;
        while (got < 3 && cyc < lim) begin
            tick();
            if (cyc == d_edge - 3) lvl = 1'b1;
            if (valid) begin
                n_assert++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_sb_empty: valid with no expected window");
                end else begin
                    e = sb_q.pop_front();
                    if (freq !== e.f8 || ovf !== e.o8 || freq5 !== e.f5 || ovf5 !== e.o5) begin
                        n_fail++;
                        $display("FAIL done_win%0d: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                                 e.idx, freq, ovf, freq5, ovf5, e.f8, e.o8, e.f5, e.o5);
                    end
                    if (e.idx == kk || e.idx == kk + 1) begin
                        n_assert++;
                        if (freq !== ((e.idx == kk) ? 8'd0 : 8'd1)) begin
                            n_fail++;
                            $display("FAIL done_edge_win%0d: freq=%0d, want %0d", e.idx, freq, (e.idx == kk) ? 0 : 1);
                        end
                    end
                end
                got++;
            end
        end
        n_assert++;
        if (got < 3) begin
            n_fail++;
            $display("FAIL done_timeout: %0d valid pulses, want 3", got);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   got = 0, last = -1, lim;
        mode = 2; ph = 0;
        lim = cyc + 20*WIN + 20;
        while (got < 20 && cyc < lim) begin
            tick();
            if (valid) begin
                n_assert++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_sb_empty: valid with no expected window");
                end else begin
                    e = sb_q.pop_front();
                    if (freq !== e.f8 || ovf !== e.o8 || freq5 !== e.f5 || ovf5 !== e.o5) begin
                        n_fail++;
                        $display("FAIL rand_win%0d: got %0d/%b %0d/%b, want %0d/%b %0d/%b",
                                 e.idx, freq, ovf, freq5, ovf5, e.f8, e.o8, e.f5, e.o5);
                    end
                end
                if (last >= 0) begin
                    n_assert++;
                    if (cyc - last != WIN) begin
                        n_fail++;
                        $display("FAIL rand_period: valid spacing %0d, want %0d", cyc - last, WIN);
                    end
                end
                last = cyc;
                got++;
            end
        end
        n_assert++;
        if (got < 20) begin
            n_fail++;
            $display("FAIL rand_timeout: %0d valid pulses, want 20", got);
        end
    endtask

    initial begin
        test_reset();
        test_period10();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_done_edge();
        test_random();
        en = 1'b0; win_on = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
